instr_encoder: RTL and testbench

Packs decoded RV32I fields (op class, ALU control, register indices, 32-bit immediate) back into 32-bit instruction words. The encoding is the inverse of the instruction decoder's field extraction and ALU-control numbering. Legal words are buffered in a small FIFO and presented with a sequential program address, for loading instruction memory from a test sequencer or boot loader. Illegal field combinations are rejected and counted.

---
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I field packer in front of a DEPTH-entry FIFO; an accepted word reaches the head one edge later.
// req_ready falls only on a full FIFO; illegal requests are consumed and counted, never queued.

module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op_class,
  input  logic [3:0]        alu_ctrl,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  input  logic              addr_clr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err,
  output logic [7:0]        err_count
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  logic [31:0]        word;
  logic               legal;
  logic [2:0]         alu_f3;
  logic               is_shift;
  logic               is_sra;
  logic               imm_fit12;
  logic               accept;
  logic               push;
  logic               full;
  logic               empty;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [ADDR_W+31:0] head;

  always_comb begin
    case (alu_ctrl)
      4'd2:       alu_f3 = 3'b100;
      4'd3:       alu_f3 = 3'b110;
      4'd4:       alu_f3 = 3'b111;
      4'd5:       alu_f3 = 3'b001;
      4'd6, 4'd7: alu_f3 = 3'b101;
      4'd8:       alu_f3 = 3'b010;
      4'd9:       alu_f3 = 3'b011;
      default:    alu_f3 = 3'b000;
    endcase
  end

  assign is_shift  = alu_ctrl inside {4'd5, 4'd6, 4'd7};
  assign is_sra    = (alu_ctrl == 4'd7);
  // 12-bit signed immediate fits when the upper 21 bits are a pure sign extension
  assign imm_fit12 = (&imm[31:11]) || !(|imm[31:11]);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (op_class)
      2'd0: begin
        word  = {((alu_ctrl == 4'd1) || is_sra) ? F7_ALT : 7'b0, rs2, rs1, alu_f3, rd, OP_R};
        legal = (alu_ctrl <= 4'd9);
      end
      2'd1: begin
        if (is_shift) begin
          word  = {is_sra ? F7_ALT : 7'b0, imm[4:0], rs1, alu_f3, rd, OP_IMM};
          legal = (imm[31:5] == '0);
        end else begin
          word  = {imm[11:0], rs1, alu_f3, rd, OP_IMM};
          legal = imm_fit12 && (alu_ctrl <= 4'd9) && (alu_ctrl != 4'd1);
        end
      end
      2'd2: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      default: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        legal = imm_fit12 && (funct3 <= 3'b010);
      end
    endcase
  end

  assign accept = req_valid && req_ready;
  assign push   = accept && legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      // clear wins over the increment; the pushed word already captured the old address
      if (addr_clr)
        addr_cnt <= '0;
      else if (push)
        addr_cnt <= addr_cnt + 1'b1;
      err <= accept && !legal;
      if (accept && !legal && (err_count != 8'hFF))
        err_count <= err_count + 1'b1;
    end
  end

  fifo #(
    .WIDTH (ADDR_W + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({addr_cnt, word}),
    .pop      (instr_valid && instr_ready),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );

  assign req_ready   = !full;
  assign instr_valid = !empty;
  assign instr       = instr_valid ? head[31:0] : '0;
  assign instr_addr  = instr_valid ? head[ADDR_W+31:32] : '0;
endmodule

// Generic circular-buffer FIFO; head visible the edge after a push into empty.
// push ignored when full, pop ignored when empty.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)
        count <= count + 1'b1;
      else if (pop_ok && !push_ok)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_dat;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized check of instr_encoder against a field-arithmetic reference model.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        op_class = '0;
  logic [3:0]        alu_ctrl = '0;
  logic [2:0]        funct3 = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [4:0]        rd = '0;
  logic [31:0]       imm = '0;
  logic              addr_clr = 1'b0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              err;
  logic [7:0]        err_count;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op_class(op_class), .alu_ctrl(alu_ctrl), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .addr_clr(addr_clr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_addr(instr_addr), .err(err), .err_count(err_count)
  );

  typedef struct {
    logic [31:0] word;
    int          addr;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  int   m_addr = 0;
  int   m_errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference encoding built from field weights; ok reports legality of the request.
  function automatic logic [31:0] model(input int op, input int alu, input int f3, input int r1,
                                        input int r2, input int rdi, input logic [31:0] im,
                                        output bit ok);
    int     f3tab[10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
    int     opc[4] = '{'h33, 'h13, 'h03, 'h23};
    longint s, u, w, f3a, f7;
    bit     fits;
    s    = longint'($signed(im));
    u    = longint'(im);
    fits = (s >= -2048) && (s <= 2047);
    f3a  = (alu < 10) ? f3tab[alu] : 0;
    f7   = (alu == 1 || alu == 7) ? 32 : 0;
    ok   = 0;
    w    = 0;
    case (op)
      0: begin
        ok = (alu < 10);
        w  = f7 * 2**25 + r2 * 2**20 + r1 * 2**15 + f3a * 2**12 + rdi * 2**7 + opc[0];
      end
      1: begin
        if (alu >= 5 && alu <= 7) begin
          ok = (u < 32);
          w  = ((alu == 7) ? 32 : 0) * 2**25 + (u % 32) * 2**20 + r1 * 2**15 + f3a * 2**12
               + rdi * 2**7 + opc[1];
        end else begin
          ok = (alu < 10) && (alu != 1) && fits;
          w  = (u % 4096) * 2**20 + r1 * 2**15 + f3a * 2**12 + rdi * 2**7 + opc[1];
        end
      end
      2: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        w  = (u % 4096) * 2**20 + r1 * 2**15 + f3 * 2**12 + rdi * 2**7 + opc[2];
      end
      default: begin
        ok = (f3 <= 2) && fits;
        w  = ((u / 32) % 128) * 2**25 + r2 * 2**20 + r1 * 2**15 + f3 * 2**12
             + (u % 32) * 2**7 + opc[3];
      end
    endcase
    return w[31:0];
  endfunction

  // One request: wait for req_ready, accept at an edge, then check the err response.
  task automatic send(input int op, input int alu, input int f3, input int r1, input int r2,
                      input int rdi, input logic [31:0] im, input bit clr, input bit pop_with,
                      input bit use_lit, input logic [31:0] lit);
    bit          ok;
    logic [31:0] w;
    int          n;
    n = 0;
    w = model(op, alu, f3, r1, r2, rdi, im, ok);
    if (use_lit) w = lit;
    op_class  = 2'(op);
    alu_ctrl  = 4'(alu);
    funct3    = 3'(f3);
    rs1       = 5'(r1);
    rs2       = 5'(r2);
    rd        = 5'(rdi);
    imm       = im;
    addr_clr  = clr;
    req_valid = 1'b1;
    if (pop_with) instr_ready = 1'b1;
    @(negedge clk);
    chk("err_idle", err, 0);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    addr_clr  = 1'b0;
    if (pop_with) instr_ready = 1'b0;
    if (ok) begin
      q.push_back('{word: w, addr: m_addr});
      m_addr = (m_addr + 1) % (1 << ADDR_W);
    end else if (m_errs < 255) begin
      m_errs++;
    end
    if (clr) m_addr = 0;
    @(negedge clk);
    chk("err_pulse", err, ok ? 0 : 1);
    chk("err_count", err_count, m_errs);
    @(posedge clk);
    #1;
  endtask

  // Every word leaving the FIFO must match the model queue head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", instr_valid, 0);
      end else begin
        mon_e = q.pop_front();
        chk("instr", instr, mon_e.word);
        chk("instr_addr", instr_addr, mon_e.addr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, alu, f3;
    logic [31:0] im;

    // reset state
    #12;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_addr", instr_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // directed encodings, consumer always ready
    instr_ready = 1'b1;
    send(0, 0, 0, 1, 2, 3, 32'd0, 0, 0, 1, 32'h002081B3);
    send(0, 1, 0, 6, 7, 5, 32'd0, 0, 0, 1, 32'h407302B3);
    send(1, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 1, 32'hFFF00093);
    send(1, 7, 0, 1, 0, 1, 32'd3, 0, 0, 1, 32'h4030D093);
    send(3, 0, 2, 1, 2, 9, 32'd8, 0, 0, 1, 32'h0020A423);
    send(2, 0, 2, 2, 0, 4, 32'd0, 0, 0, 1, 32'h00012203);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_directed", instr_valid, 0);

    // illegal requests: consumed, counted, never pushed
    send(1, 0, 0, 1, 0, 1, 32'd2048, 0, 0, 0, 32'd0);
    send(1, 1, 0, 1, 0, 1, 32'd5, 0, 0, 0, 32'd0);
    send(0, 12, 0, 1, 2, 3, 32'd0, 0, 0, 0, 32'd0);
    send(2, 0, 3, 2, 0, 4, 32'd0, 0, 0, 0, 32'd0);
    chk("err_count_4", err_count, 4);
    chk("no_push_on_illegal", instr_valid, 0);
    send(0, 0, 0, 1, 2, 3, 32'd0, 0, 0, 1, 32'h002081B3);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: fill, hold a fifth request, pop, then drain in order
    instr_ready = 1'b0;
    send(0, 0, 0, 1, 2, 3, 32'd0, 0, 0, 1, 32'h002081B3);
    chk("first_word_latency", instr_valid, 1);
    send(0, 1, 0, 6, 7, 5, 32'd0, 0, 0, 1, 32'h407302B3);
    send(1, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 1, 32'hFFF00093);
    send(1, 7, 0, 1, 0, 1, 32'd3, 0, 0, 1, 32'h4030D093);
    chk("full_req_ready", req_ready, 0);
    op_class = 2'd3; funct3 = 3'd2; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd8; req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("held_req_ready", req_ready, 0);
      chk("held_head", instr, 32'h002081B3);
    end
    @(posedge clk); #1;
    req_valid   = 1'b0;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    send(3, 0, 2, 1, 2, 0, 32'd8, 0, 0, 1, 32'h0020A423);
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    instr_ready = 1'b0;
    send(0, 3, 0, 4, 5, 6, 32'd0, 0, 1, 0, 32'd0);
    send(0, 4, 0, 7, 8, 9, 32'd0, 0, 0, 0, 32'd0);
    chk("count3_req_ready", req_ready, 1);
    send(0, 2, 0, 10, 11, 12, 32'd0, 0, 0, 0, 32'd0);
    chk("count4_req_ready", req_ready, 0);
    instr_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain_backpressure", instr_valid, 0);

    // randomized requests with random consumer stalls and occasional clears
    for (int i = 0; i < 80; i++) begin
      instr_ready = (q.size() >= DEPTH) ? 1'b1 : ($urandom_range(0, 3) != 0);
      op  = int'($urandom_range(0, 3));
      alu = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      f3  = int'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       im = $urandom;
        1:       im = $urandom_range(0, 31);
        default: im = $urandom_range(0, 4095) - 32'd2048;
      endcase
      if (op == 2) im = $urandom_range(0, 4095) - 32'd2048;
      send(op, alu, f3, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), im, ($urandom_range(0, 15) == 0), 0, 0, 32'd0);
    end
    instr_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain_random", instr_valid, 0);

    // err_count saturation
    while (m_errs < 255) send(0, 15, 0, 1, 1, 1, 32'd0, 0, 0, 0, 32'd0);
    send(0, 15, 0, 1, 1, 1, 32'd0, 0, 0, 0, 32'd0);
    chk("err_count_sat", err_count, 255);

    // reset mid-operation with buffered words and a nonzero error count
    rst_n = 1'b0;
    #2;
    q.delete(); m_addr = 0; m_errs = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    repeat (5) send(1, 1, 0, 1, 1, 1, 32'd0, 0, 0, 0, 32'd0);
    repeat (3) send(0, 0, 0, 1, 2, 3, 32'd0, 0, 0, 0, 32'd0);
    chk("pre_reset_err_count", err_count, 5);
    chk("pre_reset_valid", instr_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_instr_valid", instr_valid, 0);
    chk("midrst_instr", instr, 0);
    chk("midrst_instr_addr", instr_addr, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_err", err, 0);
    q.delete(); m_addr = 0; m_errs = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // address wrap 0,1,2,3,0 then clear together with a push
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(0, i, 0, i, i + 1, i + 2, 32'd0, 0, 0, 0, 32'd0);
    send(0, 0, 0, 3, 4, 5, 32'd0, 1, 0, 0, 32'd0);
    send(0, 0, 0, 6, 7, 8, 32'd0, 0, 0, 0, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_final", instr_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
